// File: rtl/tdm_pkg.sv
// Shared types and width helpers for the TDM frame de-multiplexer.
package tdm_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    // Counter width able to index 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Bit/slot position tracker for the TDM receiver.
// sync_load makes the current bit count as bit 0 of slot 0 before advancing.
module tdm_slot_counter
    import tdm_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int SLOT_W = 4,
    localparam int BW = cnt_w(SLOT_W),
    localparam int SW = cnt_w(NUM_CH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          adv,
    input  logic          sync_load,
    input  logic          clr,
    output logic [SW-1:0] slot_idx,
    output logic          slot_last,
    output logic          frame_last,
    output logic          at_start
);

    logic [BW-1:0] bit_cnt_q, bit_cnt_d, bit_use;
    logic [SW-1:0] slot_cnt_q, slot_cnt_d, slot_use;

    always_comb begin
        bit_use    = sync_load ? '0 : bit_cnt_q;
        slot_use   = sync_load ? '0 : slot_cnt_q;
        slot_last  = (bit_use == BW'(SLOT_W - 1));
        frame_last = slot_last && (slot_use == SW'(NUM_CH - 1));
        at_start   = (bit_cnt_q == '0) && (slot_cnt_q == '0);
        slot_idx   = slot_use;
        bit_cnt_d  = bit_cnt_q;
        slot_cnt_d = slot_cnt_q;
        if (clr) begin
            bit_cnt_d  = '0;
            slot_cnt_d = '0;
        end else if (adv) begin
            if (slot_last) begin
                bit_cnt_d  = '0;
                slot_cnt_d = frame_last ? '0 : slot_use + 1'b1;
            end else begin
                bit_cnt_d  = bit_use + 1'b1;
                slot_cnt_d = slot_use;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q  <= '0;
            slot_cnt_q <= '0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            slot_cnt_q <= slot_cnt_d;
        end
    end

endmodule

// File: rtl/tdm_frame_demux.sv
// De-serialises a 1-bit TDM stream into NUM_CH parallel SLOT_W-bit channel words.
// Define TDM_FLYWHEEL_EN to tolerate up to MISS_MAX-1 consecutive missing fsyncs.
module tdm_frame_demux
    import tdm_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int SLOT_W   = 4,
    parameter int MISS_MAX = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     din,
    input  logic                     fsync,
    output logic [NUM_CH*SLOT_W-1:0] ch_out,
    output logic                     frame_valid,
    output logic                     locked,
    output logic                     sync_err
);

    localparam int SW = cnt_w(NUM_CH);

    state_e                         state_q, state_d;
    logic [SLOT_W-1:0]              shreg_q, shreg_d, word;
    logic [NUM_CH-1:0][SLOT_W-1:0]  staging_q, staging_d, commit_w;
    logic [NUM_CH*SLOT_W-1:0]       ch_out_q, ch_out_d;
    logic                           fv_q, fv_d, se_q, se_d;
    logic                           is_locked, sync_load, miss_drop, take;
    logic [SW-1:0]                  slot_idx;
    logic                           slot_last, frame_last, at_start;

    assign is_locked = (state_q == LOCKED);
    // A fsync re-anchors the frame unless it lands exactly where one was expected.
    assign sync_load = fsync && !(is_locked && at_start);
    assign word      = SLOT_W'({shreg_q, din});

`ifdef TDM_FLYWHEEL_EN
    localparam int MW = cnt_w(MISS_MAX + 1);
    logic [MW-1:0] miss_q, miss_d;

    assign miss_drop = is_locked && at_start && !fsync && (miss_q == MW'(MISS_MAX - 1));

    always_comb begin
        miss_d = miss_q;
        if (en && is_locked && at_start) begin
            if (fsync || miss_drop) miss_d = '0;
            else                    miss_d = miss_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) miss_q <= '0;
        else        miss_q <= miss_d;
    end
`else
    assign miss_drop = is_locked && at_start && !fsync;
`endif

    assign take = en && (is_locked ? !miss_drop : fsync);

    tdm_slot_counter #(
        .NUM_CH (NUM_CH),
        .SLOT_W (SLOT_W)
    ) u_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .adv        (take),
        .sync_load  (sync_load),
        .clr        (en && miss_drop),
        .slot_idx   (slot_idx),
        .slot_last  (slot_last),
        .frame_last (frame_last),
        .at_start   (at_start)
    );

    always_comb begin
        commit_w             = staging_q;
        commit_w[NUM_CH-1]   = word;
        state_d              = state_q;
        shreg_d              = shreg_q;
        staging_d            = staging_q;
        ch_out_d             = ch_out_q;
        fv_d                 = 1'b0;
        se_d                 = 1'b0;
        if (en) begin
            if (!is_locked && fsync) state_d = LOCKED;
            else if (miss_drop)      state_d = HUNT;
            if (is_locked && sync_load) se_d = 1'b1;
            if (take) begin
                shreg_d = word;
                if (slot_last) staging_d[slot_idx] = word;
                if (frame_last) begin
                    ch_out_d = commit_w;
                    fv_d     = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= HUNT;
            shreg_q   <= '0;
            staging_q <= '0;
            ch_out_q  <= '0;
            fv_q      <= 1'b0;
            se_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            staging_q <= staging_d;
            ch_out_q  <= ch_out_d;
            fv_q      <= fv_d;
            se_q      <= se_d;
        end
    end

    assign ch_out      = ch_out_q;
    assign frame_valid = fv_q;
    assign locked      = is_locked;
    assign sync_err    = se_q;

endmodule

// File: tb/tb_tdm_frame_demux.sv
// Self-checking bench for tdm_frame_demux: constant vector table, directed corner cases, random vs model.
module tb_tdm_frame_demux;

    localparam int NUM_CH   = 2;
    localparam int SLOT_W   = 4;
    localparam int N        = NUM_CH * SLOT_W;
    localparam int MISS_MAX = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0, din = 1'b0, fsync = 1'b0;
    logic [N-1:0] ch_out;
    logic         frame_valid, locked, sync_err;

    tdm_frame_demux #(.NUM_CH(NUM_CH), .SLOT_W(SLOT_W), .MISS_MAX(MISS_MAX)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .din         (din),
        .fsync       (fsync),
        .ch_out      (ch_out),
        .frame_valid (frame_valid),
        .locked      (locked),
        .sync_err    (sync_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int fv_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks bit position within the frame and collects frame bits.
    bit           m_locked;
    int           m_pos, m_miss;
    bit           m_bits [N];
    logic [N-1:0] m_ch;
    bit           m_fv, m_se;

    function automatic void m_reset();
        m_locked = 0; m_pos = 0; m_miss = 0; m_ch = '0; m_fv = 0; m_se = 0;
    endfunction

    function automatic void m_step(input bit e, input bit d, input bit f);
        bit acc;
        acc  = 0;
        m_fv = 0;
        m_se = 0;
        if (!e) return;
        if (!m_locked) begin
            if (f) begin m_locked = 1; m_pos = 0; m_miss = 0; acc = 1; end
        end else if (m_pos == 0) begin
            if (f) begin m_miss = 0; acc = 1; end
            else begin
`ifdef TDM_FLYWHEEL_EN
                m_miss++;
                if (m_miss >= MISS_MAX) begin m_locked = 0; m_miss = 0; end
                else acc = 1;
`else
                m_locked = 0;
`endif
            end
        end else if (f) begin
            m_se = 1; m_pos = 0; acc = 1;
        end else begin
            acc = 1;
        end
        if (acc) begin
            m_bits[m_pos] = d;
            m_pos++;
            if (m_pos == N) begin
                m_pos = 0;
                m_fv  = 1;
                for (int k = 0; k < NUM_CH; k++)
                    for (int b = 0; b < SLOT_W; b++)
                        m_ch[k*SLOT_W + SLOT_W-1-b] = m_bits[k*SLOT_W + b];
            end
        end
    endfunction

    task automatic step(input bit e, input bit d, input bit f, input bit cmp);
        @(negedge clk);
        en = e; din = d; fsync = f;
        m_step(e, d, f);
        @(posedge clk);
        #1;
        if (frame_valid) fv_cnt++;
        if (cmp) begin
            chk("ch_out", 32'(ch_out), 32'(m_ch));
            chk("frame_valid", 32'(frame_valid), 32'(m_fv));
            chk("locked", 32'(locked), 32'(m_locked));
            chk("sync_err", 32'(sync_err), 32'(m_se));
        end
    endtask

    // Stream byte: first transmitted bit in the MSB.
    task automatic send_frame(input logic [7:0] s, input bit with_fs);
        for (int b = 0; b < N; b++) step(1'b1, s[7-b], with_fs && (b == 0), 1'b1);
    endtask

    typedef struct {
        bit           din;
        bit           fs;
        logic [N-1:0] ch;
        bit           fv;
    } vec_t;

    vec_t         tv [24];
    logic [7:0]   streams [3];

    initial begin
        m_reset();
        repeat (3) @(negedge clk);
        chk("rst_ch_out", 32'(ch_out), 0);
        chk("rst_frame_valid", 32'(frame_valid), 0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_sync_err", 32'(sync_err), 0);
        rst_n = 1'b1;

        // Three back-to-back frames A5 / 3C / F0 with correct fsyncs.
        streams = '{8'hA5, 8'h3C, 8'hF0};
        for (int i = 0; i < 24; i++) begin
            tv[i].din = streams[i/8][7 - (i%8)];
            tv[i].fs  = (i % 8) == 0;
            tv[i].ch  = (i < 7) ? 8'h00 : (i < 15) ? 8'h5A : (i < 23) ? 8'hC3 : 8'h0F;
            tv[i].fv  = (i == 7) || (i == 15) || (i == 23);
        end
        for (int i = 0; i < 24; i++) begin
            step(1'b1, tv[i].din, tv[i].fs, 1'b0);
            chk("tv_ch_out", 32'(ch_out), 32'(tv[i].ch));
            chk("tv_frame_valid", 32'(frame_valid), 32'(tv[i].fv));
            chk("tv_locked", 32'(locked), 1);
            chk("tv_sync_err", 32'(sync_err), 0);
        end

        // en toggling: commit follows the 8th qualified bit.
        for (int b = 0; b < N; b++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1);
            step(1'b1, streams[0][7-b], b == 0, 1'b1);
        end
        chk("stall_ch_out", 32'(ch_out), 32'h5A);
        chk("stall_fv", 32'(frame_valid), 1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        chk("stall_hold", 32'(ch_out), 32'h5A);

        // Misplaced fsync on bit 5 starts the 0x96 frame.
        for (int b = 0; b < 5; b++) step(1'b1, streams[0][7-b], b == 0, 1'b1);
        fv_cnt = 0;
        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk("misplaced_sync_err", 32'(sync_err), 1);
        chk("misplaced_locked", 32'(locked), 1);
        for (int b = 1; b < N; b++) step(1'b1, 8'h96 >> (7-b), 1'b0, 1'b1);
        chk("resync_ch_out", 32'(ch_out), 32'h69);
        chk("resync_fv_cnt", 32'(fv_cnt), 1);

        // Missing fsync at the frame boundary.
        send_frame(8'h3C, 1'b1);
        fv_cnt = 0;
`ifdef TDM_FLYWHEEL_EN
        send_frame(8'h5A, 1'b0);
        send_frame(8'h96, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("fly_fv_cnt", 32'(fv_cnt), 2);
        chk("fly_ch_out", 32'(ch_out), 32'h69);
        chk("fly_locked", 32'(locked), 0);
`else
        step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("miss_locked", 32'(locked), 0);
        for (int b = 1; b < N; b++) step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("miss_ch_out", 32'(ch_out), 32'hC3);
        chk("miss_fv_cnt", 32'(fv_cnt), 0);
`endif

        // Reset mid-frame.
        send_frame(8'hA5, 1'b1);
        for (int b = 0; b < 3; b++) step(1'b1, streams[1][7-b], b == 0, 1'b1);
        @(negedge clk);
        en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_ch_out", 32'(ch_out), 0);
        chk("midrst_locked", 32'(locked), 0);
        chk("midrst_fv", 32'(frame_valid), 0);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(8'hF0, 1'b1);
        chk("relock_ch_out", 32'(ch_out), 32'h0F);

        // Random traffic against the model.
        for (int i = 0; i < 800; i++) begin
            bit e, d, f;
            e = $urandom_range(3) != 0;
            d = 1'($urandom_range(1));
            if (!m_locked)        f = $urandom_range(4) == 0;
            else if (m_pos == 0)  f = $urandom_range(9) != 0;
            else                  f = $urandom_range(29) == 0;
            step(e, d, f, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
